// File: rtl/udp_test_pkg.sv
// Shared types and pattern helpers for the AXI-Stream UDP traffic generator/checker.
// LFSR_POLY is only consumed when TRAFFIC_GEN_RX_BACKPRESSURE_EN is defined.
package udp_test_pkg;

  typedef enum logic [1:0] {
    GEN_IDLE = 2'd0,
    GEN_SEND = 2'd1,
    GEN_DONE = 2'd2
  } gen_state_t;

  typedef enum logic {
    CHK_IDLE  = 1'b0,
    CHK_CHECK = 1'b1
  } chk_state_t;

  localparam int unsigned MAX_KEEP_W = 256;

  // Galois form of x^32 + x^22 + x^2 + x^1 + 1, right-shifting
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  function automatic logic [31:0] pattern_word(input logic [31:0] p, input logic [31:0] b,
                                               input logic [31:0] k, input logic [31:0] lanes);
    return (p << 16) + (b * lanes) + k;
  endfunction

  function automatic logic [MAX_KEEP_W-1:0] last_keep(input logic [31:0] len, input logic [31:0] kw);
    logic [31:0] rem;
    logic [MAX_KEEP_W-1:0] keep;
    rem = len % kw;
    for (int i = 0; i < MAX_KEEP_W; i++) begin
      keep[i] = ((rem == 32'd0) && (32'(i) < kw)) || (32'(i) < rem) ? 1'b1 : 1'b0;
    end
    return keep;
  endfunction

endpackage

// File: rtl/axis_pkt_checker.sv
// Receive-side pattern checker: tracks its own expected packet/beat, counts packets and errors.
// Optional LFSR backpressure under TRAFFIC_GEN_RX_BACKPRESSURE_EN.
module axis_pkt_checker
  import udp_test_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_F00D
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  busy,
  input  logic [LEN_WIDTH-1:0]  last_beat,
  input  logic [KEEP_WIDTH-1:0] last_keep_in,
  input  logic                  rx_tvalid,
  output logic                  rx_tready,
  input  logic                  rx_tlast,
  input  logic [DATA_WIDTH-1:0] rx_tdata,
  input  logic [KEEP_WIDTH-1:0] rx_tkeep,
  output logic [CNT_WIDTH-1:0]  rx_pkt_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  localparam int unsigned LANES = DATA_WIDTH / 32;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  chk_state_t chk_state_r, chk_state_nxt_s;
  logic [CNT_WIDTH-1:0]  exp_pkt_r, rx_pkt_cnt_r, err_cnt_r;
  logic [LEN_WIDTH-1:0]  exp_beat_r;
  logic                  exp_last_s, accept_s, mismatch_s, tready_s;
  logic [KEEP_WIDTH-1:0] exp_keep_s;
  logic [DATA_WIDTH-1:0] exp_data_s, byte_mask_s;

`ifdef TRAFFIC_GEN_RX_BACKPRESSURE_EN
  logic [31:0] lfsr_r;

  // Free-running backpressure LFSR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= LFSR_SEED;
    end else if (lfsr_r[0]) begin
      lfsr_r <= (lfsr_r >> 1) ^ LFSR_POLY;
    end else begin
      lfsr_r <= lfsr_r >> 1;
    end
  end

  assign tready_s = (chk_state_r == CHK_CHECK) && (lfsr_r[1:0] != 2'b00);
`else
  logic unused_s;
  assign unused_s = ^{LFSR_SEED, LFSR_POLY};
  assign tready_s = busy;
`endif

  // Checker state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_state_r <= CHK_IDLE;
    else        chk_state_r <= chk_state_nxt_s;
  end

  // Checker next state
  always_comb begin
    chk_state_nxt_s = chk_state_r;
    case (chk_state_r)
      CHK_IDLE:  if (clr) chk_state_nxt_s = CHK_CHECK; else chk_state_nxt_s = CHK_IDLE;
      CHK_CHECK: if (clr) chk_state_nxt_s = CHK_CHECK;
                 else if (!busy) chk_state_nxt_s = CHK_IDLE;
                 else chk_state_nxt_s = CHK_CHECK;
      default:   chk_state_nxt_s = CHK_IDLE;
    endcase
  end

  // Expected beat image and keep-masked comparison
  always_comb begin
    exp_data_s  = '0;
    byte_mask_s = '0;
    exp_last_s  = (exp_beat_r == last_beat);
    exp_keep_s  = exp_last_s ? last_keep_in : {KEEP_WIDTH{1'b1}};
    for (int k = 0; k < LANES; k++) begin
      exp_data_s[32*k +: 32] = pattern_word(32'(exp_pkt_r), 32'(exp_beat_r), 32'(k), 32'(LANES));
    end
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      byte_mask_s[8*i +: 8] = {8{exp_keep_s[i]}};
    end
    mismatch_s = (((rx_tdata ^ exp_data_s) & byte_mask_s) != '0) ||
                 (rx_tkeep != exp_keep_s) || (rx_tlast != exp_last_s);
    accept_s   = rx_tvalid && tready_s && (chk_state_r == CHK_CHECK);
  end

  // Expected position, packet and error counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_pkt_r    <= '0;
      exp_beat_r   <= '0;
      rx_pkt_cnt_r <= '0;
      err_cnt_r    <= '0;
    end else if (clr) begin
      exp_pkt_r    <= '0;
      exp_beat_r   <= '0;
      rx_pkt_cnt_r <= '0;
      err_cnt_r    <= '0;
    end else if (accept_s) begin
      if (mismatch_s && (err_cnt_r != {CNT_WIDTH{1'b1}})) err_cnt_r <= err_cnt_r + CNT_ONE;
      if (rx_tlast) rx_pkt_cnt_r <= rx_pkt_cnt_r + CNT_ONE;
      // Either side's tlast closes the packet so one bad beat cannot skew the rest
      if (rx_tlast || exp_last_s) begin
        exp_beat_r <= '0;
        exp_pkt_r  <= exp_pkt_r + CNT_ONE;
      end else begin
        exp_beat_r <= exp_beat_r + LEN_ONE;
      end
    end
  end

  assign rx_tready  = tready_s;
  assign rx_pkt_cnt = rx_pkt_cnt_r;
  assign err_cnt    = err_cnt_r;

endmodule

// File: rtl/axis_udp_traffic_gen_chk.sv
// AXI-Stream loopback traffic generator plus checker for the UDP/IP/Eth stack XDMA port.
// Optional RX backpressure: define TRAFFIC_GEN_RX_BACKPRESSURE_EN.
module axis_udp_traffic_gen_chk
  import udp_test_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_F00D
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [CNT_WIDTH-1:0]  cfg_pkt_num,
  input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
  output logic                  tx_axis_tvalid,
  input  logic                  tx_axis_tready,
  output logic                  tx_axis_tlast,
  output logic [DATA_WIDTH-1:0] tx_axis_tdata,
  output logic [KEEP_WIDTH-1:0] tx_axis_tkeep,
  output logic [USER_WIDTH-1:0] tx_axis_tuser,
  input  logic                  rx_axis_tvalid,
  output logic                  rx_axis_tready,
  input  logic                  rx_axis_tlast,
  input  logic [DATA_WIDTH-1:0] rx_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] rx_axis_tkeep,
  input  logic [USER_WIDTH-1:0] rx_axis_tuser,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  tx_pkt_cnt,
  output logic [CNT_WIDTH-1:0]  rx_pkt_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  localparam int unsigned LANES = DATA_WIDTH / 32;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  gen_state_t gen_state_r, gen_state_nxt_s;
  logic                  busy_r, done_r, stop_pend_r, tvalid_r, tlast_r;
  logic [CNT_WIDTH-1:0]  num_r, tx_pkt_cnt_r, nxt_pkt_s, rx_pkt_cnt_s, err_cnt_s;
  logic [LEN_WIDTH-1:0]  last_beat_r, beat_r, nxt_beat_s, cfg_len_s, cfg_last_beat_s, sel_last_beat_s;
  logic [KEEP_WIDTH-1:0] last_keep_r, tkeep_r, nxt_keep_s, cfg_last_keep_s, sel_last_keep_s;
  logic [DATA_WIDTH-1:0] tdata_r, nxt_data_s;
  logic                  start_s, accept_s, pkt_end_s, run_end_s, nxt_last_s;
  logic                  unused_tuser_s;

  assign unused_tuser_s = ^rx_axis_tuser;
  assign start_s   = cfg_start && !busy_r;
  assign accept_s  = tvalid_r && tx_axis_tready;
  assign pkt_end_s = accept_s && tlast_r;
  assign run_end_s = pkt_end_s && (stop_pend_r || cfg_stop ||
                     ((num_r != '0) && (tx_pkt_cnt_r == (num_r - CNT_ONE))));

  // Config decode and next-beat image
  always_comb begin
    cfg_len_s       = (cfg_pkt_len == '0) ? LEN_ONE : cfg_pkt_len;
    cfg_last_beat_s = LEN_WIDTH'((32'(cfg_len_s) - 32'd1) / 32'(KEEP_WIDTH));
    cfg_last_keep_s = KEEP_WIDTH'(last_keep(32'(cfg_len_s), 32'(KEEP_WIDTH)));
    if (start_s) begin
      nxt_pkt_s       = '0;
      nxt_beat_s      = '0;
      sel_last_beat_s = cfg_last_beat_s;
      sel_last_keep_s = cfg_last_keep_s;
    end else if (tlast_r) begin
      nxt_pkt_s       = tx_pkt_cnt_r + CNT_ONE;
      nxt_beat_s      = '0;
      sel_last_beat_s = last_beat_r;
      sel_last_keep_s = last_keep_r;
    end else begin
      nxt_pkt_s       = tx_pkt_cnt_r;
      nxt_beat_s      = beat_r + LEN_ONE;
      sel_last_beat_s = last_beat_r;
      sel_last_keep_s = last_keep_r;
    end
    nxt_last_s = (nxt_beat_s == sel_last_beat_s);
    nxt_keep_s = nxt_last_s ? sel_last_keep_s : {KEEP_WIDTH{1'b1}};
    nxt_data_s = '0;
    for (int k = 0; k < LANES; k++) begin
      nxt_data_s[32*k +: 32] = pattern_word(32'(nxt_pkt_s), 32'(nxt_beat_s), 32'(k), 32'(LANES));
    end
  end

  // Generator state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) gen_state_r <= GEN_IDLE;
    else        gen_state_r <= gen_state_nxt_s;
  end

  // Generator next state
  always_comb begin
    gen_state_nxt_s = gen_state_r;
    case (gen_state_r)
      GEN_IDLE: if (start_s)   gen_state_nxt_s = GEN_SEND; else gen_state_nxt_s = GEN_IDLE;
      GEN_SEND: if (run_end_s) gen_state_nxt_s = GEN_DONE; else gen_state_nxt_s = GEN_SEND;
      GEN_DONE: if (start_s)   gen_state_nxt_s = GEN_SEND; else gen_state_nxt_s = GEN_DONE;
      default:  gen_state_nxt_s = GEN_IDLE;
    endcase
  end

  // Run configuration, TX beat registers and status
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      num_r        <= '0;
      last_beat_r  <= '0;
      last_keep_r  <= '0;
      beat_r       <= '0;
      tx_pkt_cnt_r <= '0;
      tvalid_r     <= 1'b0;
      tlast_r      <= 1'b0;
      tdata_r      <= '0;
      tkeep_r      <= '0;
      stop_pend_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else if (start_s) begin
      num_r        <= cfg_pkt_num;
      last_beat_r  <= cfg_last_beat_s;
      last_keep_r  <= cfg_last_keep_s;
      beat_r       <= nxt_beat_s;
      tx_pkt_cnt_r <= '0;
      tvalid_r     <= 1'b1;
      tlast_r      <= nxt_last_s;
      tdata_r      <= nxt_data_s;
      tkeep_r      <= nxt_keep_s;
      stop_pend_r  <= 1'b0;
      busy_r       <= 1'b1;
      done_r       <= 1'b0;
    end else begin
      if (accept_s) begin
        beat_r  <= nxt_beat_s;
        tlast_r <= nxt_last_s;
        tdata_r <= nxt_data_s;
        tkeep_r <= nxt_keep_s;
      end
      if (pkt_end_s) tx_pkt_cnt_r <= tx_pkt_cnt_r + CNT_ONE;
      if (run_end_s) tvalid_r <= 1'b0;
      if ((gen_state_r == GEN_SEND) && cfg_stop) stop_pend_r <= 1'b1;
      // Completion waits for the looped-back stream to drain
      if ((gen_state_r == GEN_DONE) && busy_r && (rx_pkt_cnt_s == tx_pkt_cnt_r)) begin
        done_r <= 1'b1;
        busy_r <= 1'b0;
      end
    end
  end

  axis_pkt_checker #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .LFSR_SEED  (LFSR_SEED)
  ) u_checker (
    .clk          (CLK),
    .rst_n        (RST_N),
    .clr          (start_s),
    .busy         (busy_r),
    .last_beat    (last_beat_r),
    .last_keep_in (last_keep_r),
    .rx_tvalid    (rx_axis_tvalid),
    .rx_tready    (rx_axis_tready),
    .rx_tlast     (rx_axis_tlast),
    .rx_tdata     (rx_axis_tdata),
    .rx_tkeep     (rx_axis_tkeep),
    .rx_pkt_cnt   (rx_pkt_cnt_s),
    .err_cnt      (err_cnt_s)
  );

  assign tx_axis_tvalid = tvalid_r;
  assign tx_axis_tlast  = tlast_r;
  assign tx_axis_tdata  = tdata_r;
  assign tx_axis_tkeep  = tkeep_r;
  assign tx_axis_tuser  = '0;
  assign busy           = busy_r;
  assign done           = done_r;
  assign tx_pkt_cnt     = tx_pkt_cnt_r;
  assign rx_pkt_cnt     = rx_pkt_cnt_s;
  assign err_cnt        = err_cnt_s;

endmodule
